// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer driving an external 1-bit ALU slice.
// Operands are shifted out LSB first and the result is shifted in from the MSB.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cn,
  output logic [2:0]       slice_s,
  input  logic             slice_y,
  input  logic             slice_cn_1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [2:0]       op_r;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;
  logic             run;

  assign run = (state == RUN);

  // Slice inputs are gated so the slice sees zeros outside RUN.
  assign slice_a  = run & a_sr[0];
  assign slice_b  = run & b_sr[0];
  assign slice_cn = run & carry;
  assign slice_s  = op_r;

  assign busy   = run;
  assign done   = (state == FIN);
  assign result = res_sr;
  assign cout   = cout_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_r   <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            op_r   <= op;
            carry  <= cin;
            cnt    <= '0;
            res_sr <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {slice_y, res_sr[WIDTH-1:1]};
          carry  <= slice_cn_1;
          if (cnt == LAST) begin
            cout_r <= slice_cn_1;
            state  <= FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: table-driven check of the serial ALU sequencer
// against a behavioural 1-bit slice model.
module tb_alu_serial_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [2:0] op;
  logic       cin;
  logic       slice_a;
  logic       slice_b;
  logic       slice_cn;
  logic [2:0] slice_s;
  logic       slice_y;
  logic       slice_cn_1;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
  } vec_t;

  vec_t tbl [7];

  alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .op         (op),
    .cin        (cin),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cn   (slice_cn),
    .slice_s    (slice_s),
    .slice_y    (slice_y),
    .slice_cn_1 (slice_cn_1),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .cout       (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    slice_y    = 1'b0;
    slice_cn_1 = 1'b0;
    case (slice_s)
      3'b000: begin
        slice_y    = slice_a ^ slice_b ^ slice_cn;
        slice_cn_1 = (slice_a & slice_b) | (slice_a & slice_cn)
                   | (slice_b & slice_cn);
      end
      3'b001: slice_y = slice_a & slice_b;
      default: slice_y = slice_a | slice_b;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_in  = v.a;
    b_in  = v.b;
    op    = v.op;
    cin   = v.cin;
    start = 1'b1;
  endtask

  // Sample cycles after the accepting edge; optionally pulse a stray START.
  task automatic collect(input vec_t v, input int glitch, input string nm);
    int busy_n;
    int done_at;
    int s_bad;
    busy_n  = 0;
    done_at = 0;
    s_bad   = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (busy) begin
        busy_n++;
        if (slice_s !== v.op) s_bad++;
      end
      if (done) begin
        done_at = c;
        chk({nm, " slice_zero"}, {slice_a, slice_b, slice_cn}, 0);
        chk({nm, " slice_s_fin"}, slice_s, v.op);
        break;
      end
      if (c == glitch) begin
        start = 1'b1;
        a_in  = 8'h11;
        b_in  = 8'h22;
        op    = 3'b001;
        cin   = 1'b1;
      end
      if (c == glitch + 1) start = 1'b0;
    end
    chk({nm, " busy_cycles"}, busy_n, 8);
    chk({nm, " done_cycle"}, done_at, 9);
    chk({nm, " slice_s_run"}, s_bad, 0);
    chk({nm, " result"}, result, v.res);
    chk({nm, " cout"}, cout, v.cout);
    @(negedge clk);
    @(negedge clk);
    chk({nm, " result_hold"}, result, v.res);
    chk({nm, " busy_idle"}, busy, 0);
  endtask

  initial begin
    int done_n;
    int busy_err;
    int done_err;
    n_vec = 0;
    n_bad = 0;

    tbl[0] = '{3'b000, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{3'b000, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{3'b001, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    tbl[4] = '{3'b000, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    tbl[5] = '{3'b001, 8'hFF, 8'h0F, 1'b1, 8'h0F, 1'b0};
    tbl[6] = '{3'b000, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    // Reset with START held high: START must be ignored.
    rst_n = 1'b0;
    drive(tbl[0]);
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst cout", cout, 0);
    chk("rst slice", {slice_a, slice_b, slice_cn}, 0);
    chk("rst slice_s", slice_s, 0);

    // First edge with reset released accepts the pending START.
    rst_n = 1'b1;
    collect(tbl[0], 0, "first");

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      collect(tbl[i], 0, $sformatf("vec%0d", i));
    end

    // Stray START and operand changes during RUN.
    @(negedge clk);
    drive(tbl[0]);
    collect(tbl[0], 3, "glitch");

    // Reset in RUN cycle 4 aborts without DONE.
    @(negedge clk);
    drive(tbl[2]);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort cout", cout, 0);
    rst_n = 1'b1;
    done_n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("abort no_done", done_n, 0);
    @(negedge clk);
    drive(tbl[4]);
    collect(tbl[4], 0, "after_abort");

    // START held high: one operation every 10 cycles.
    @(negedge clk);
    drive(tbl[0]);
    done_n   = 0;
    busy_err = 0;
    done_err = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (busy !== ((c % 10) >= 1 && (c % 10) <= 8)) busy_err++;
      if (done !== ((c % 10) == 9)) done_err++;
      if (done) begin
        done_n++;
        chk($sformatf("b2b result c%0d", c), result, 8'h96);
      end
    end
    start = 1'b0;
    chk("b2b busy_pattern", busy_err, 0);
    chk("b2b done_pattern", done_err, 0);
    chk("b2b done_count", done_n, 3);
    repeat (3) @(negedge clk);
    chk("b2b idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  request a new operation; sampled only in IDLE.
REQ-005 A_IN  input  WIDTH  operand A; captured when START is accepted.
REQ-006 B_IN  input  WIDTH  operand B; captured when START is accepted.
REQ-007 OP  input  3  slice function select; captured when START is accepted.
REQ-008 CIN  input  1  initial carry into bit 0; captured when START is accepted.
REQ-009 SLICE_A  output  1  A bit to the 1-bit ALU slice.
REQ-010 SLICE_B  output  1  B bit to the slice.
REQ-011 SLICE_CN  output  1  carry-in to the slice.
REQ-012 SLICE_S  output  3  function select to the slice (S2..S0).
REQ-013 SLICE_Y  input  1  slice result bit.
REQ-014 SLICE_CN_1  input  1  slice carry-out.
REQ-015 BUSY  output  1  high while bits are being processed.
REQ-016 DONE  output  1  one-cycle completion pulse.
REQ-017 RESULT  output  WIDTH  assembled result; LSB = bit 0.
REQ-018 COUT  output  1  final carry-out of bit WIDTH-1.

Function
REQ-019 The block SHALL be an FSM with states IDLE, RUN, FIN.
REQ-020 IDLE + START=1 -> capture A_IN, B_IN, OP, CIN; clear bit counter; clear RESULT shift register; go RUN.
REQ-021 IDLE + START=0 -> stay IDLE; RESULT and COUT hold.
REQ-022 In RUN, SLICE_A/SLICE_B SHALL equal bit 0 of the A/B shift registers, SLICE_CN the carry register, SLICE_S the captured OP (combinational from registers).
REQ-023 Each RUN cycle: shift A and B right by 1; shift SLICE_Y into RESULT MSB (shift right); carry register <= SLICE_CN_1; counter +1.
REQ-024 RUN with counter = WIDTH-1 -> perform the last shift, COUT <= SLICE_CN_1, go FIN.
REQ-025 FIN -> DONE=1 for exactly that cycle; go IDLE next cycle unconditionally.
REQ-026 Latency: START sampled at edge k -> BUSY high cycles k+1..k+WIDTH; DONE high cycle k+WIDTH+1; RESULT/COUT valid from that cycle.
REQ-027 BUSY SHALL be 1 only in RUN; DONE only in FIN.
REQ-028 START in RUN or FIN SHALL be ignored (no queuing); A_IN/B_IN/OP/CIN changes during RUN SHALL have no effect.
REQ-029 START held high continuously SHALL begin a new operation on the first IDLE cycle after FIN (back-to-back throughput WIDTH+2 cycles).
REQ-030 RESULT SHALL hold its value from FIN until the next accepted START; COUT likewise.
REQ-031 In IDLE and FIN, SLICE_A, SLICE_B, SLICE_CN SHALL be 0 and SLICE_S SHALL hold the last captured OP.
REQ-032 Counter width SHALL be ceil(log2(WIDTH)); no wrap beyond WIDTH-1 occurs.

Reset
REQ-033 RST_N=0 at a rising edge SHALL force IDLE; BUSY=0, DONE=0, RESULT=0, COUT=0, SLICE_*=0, counter=0, shift/carry registers=0.
REQ-034 Reset asserted mid-RUN SHALL abort the operation with no DONE pulse; no partial RESULT retained.
REQ-035 START coincident with RST_N=0 SHALL be ignored.
REQ-036 First START is accepted on the first edge with RST_N=1.

Verification (WIDTH=8, bench slice model: OP=000 -> Y=A^B^Cn, Cn_1=majority(A,B,Cn); OP=001 -> Y=A&B, Cn_1=0)
REQ-037 OP=000, A=0x5A, B=0x3C, CIN=0, START 1 cycle -> BUSY 8 cycles, DONE at cycle 9, RESULT=0x96, COUT=0.
REQ-038 OP=000, A=0xFF, B=0x01, CIN=0 -> RESULT=0x00, COUT=1; same with CIN=1, B=0x00 -> RESULT=0x00, COUT=1.
REQ-039 OP=001, A=0xF0, B=0x3C -> RESULT=0x30, COUT=0; SLICE_S=001 throughout RUN.
REQ-040 START pulsed again at RUN cycle 3 with different operands -> ignored; RESULT equals first operation only.
REQ-041 RST_N low at RUN cycle 4 -> next cycle BUSY=0, RESULT=0, no DONE; subsequent START completes correctly.
REQ-042 START held high for 30 cycles -> DONE pulses every 10 cycles, BUSY low exactly one cycle (IDLE) plus FIN between operations.
